// File: rtl/bp_fe_bht_pkg.sv
// bp_fe_bht_pkg: shared BHT types, init constant and saturating counter update.
package bp_fe_bht_pkg;
    typedef enum logic [1:0] {INIT, RUN, UPD_WR} bht_state_e;
    typedef logic [1:0] bht_ctr_t;
    localparam bht_ctr_t CTR_INIT = 2'b01;
    function automatic bht_ctr_t bht_next_ctr(input bht_ctr_t c, input logic taken);
        return taken ? ((c == 2'b11) ? c : c + 2'b01) : ((c == 2'b00) ? c : c - 2'b01);
    endfunction
endpackage

// File: rtl/bp_fe_bht_mem.sv
// bp_fe_bht_mem: single-port counter table, one read or write per cycle, registered read.
module bp_fe_bht_mem
    import bp_fe_bht_pkg::*;
#(
    parameter int IDX_W = 6
) (
    input  logic             clk_i,
    input  logic             en,
    input  logic             we,
    input  logic [IDX_W-1:0] addr,
    input  logic [1:0]       wdata,
    output logic [1:0]       rdata
);
    bht_ctr_t mem [2**IDX_W];
    always_ff @(posedge clk_i) begin
        if (en) begin
            if (we) mem[addr] <= wdata;
            else rdata <= mem[addr];
        end
    end
endmodule

// File: rtl/bp_fe_bht_ctrl.sv
// bp_fe_bht_ctrl: 2-bit BHT controller arbitrating lookups and updates on one table port.
// Define BP_FE_BHT_FLUSH_EN to add flush_i, which re-initialises the table.
module bp_fe_bht_ctrl
    import bp_fe_bht_pkg::*;
#(
    parameter int IDX_W        = 6,
    parameter int STARVE_LIMIT = 3
) (
    input  logic             clk_i,
    input  logic             reset_n_i,
    input  logic             lookup_v_i,
    input  logic [IDX_W-1:0] lookup_idx_i,
    output logic             lookup_ready_o,
    output logic             pred_v_o,
    output logic             pred_taken_o,
    output logic [1:0]       pred_ctr_o,
    input  logic             upd_v_i,
    input  logic [IDX_W-1:0] upd_idx_i,
    input  logic             upd_taken_i,
    output logic             upd_ready_o,
    output logic             init_done_o
`ifdef BP_FE_BHT_FLUSH_EN
    ,
    input  logic             flush_i
`endif
);
    localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

    bht_state_e       state, state_n;
    logic [IDX_W-1:0] init_idx, upd_idx_q, mem_addr;
    logic [SW-1:0]    starve;
    logic             upd_taken_q, pred_v_q, flush_pend;
    logic             run, starved, lk_gnt, up_gnt, mem_en, mem_we;
    bht_ctr_t         mem_wdata, mem_rdata;

`ifdef BP_FE_BHT_FLUSH_EN
    // A pending flush survives the update write and is consumed by RUN or INIT.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) flush_pend <= 1'b0;
        else flush_pend <= flush_i || (flush_pend && state == UPD_WR);
    end
`else
    assign flush_pend = 1'b0;
`endif

    assign run            = state == RUN && !flush_pend;
    assign starved        = starve == SW'(STARVE_LIMIT);
    assign lookup_ready_o = run && !(starved && upd_v_i);
    assign upd_ready_o    = run && (starved || !lookup_v_i);
    assign lk_gnt         = lookup_v_i && lookup_ready_o;
    assign up_gnt         = upd_v_i && upd_ready_o;

    always_comb begin
        state_n   = state;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = lookup_idx_i;
        mem_wdata = CTR_INIT;
        state_n   = (state == INIT)   ? ((init_idx == '1 && !flush_pend) ? RUN : INIT) :
                    (state == UPD_WR) ? RUN :
                    flush_pend        ? INIT :
                    up_gnt            ? UPD_WR : RUN;
        mem_en    = state != RUN || lk_gnt || up_gnt;
        mem_we    = state != RUN;
        mem_addr  = (state == INIT)   ? init_idx :
                    (state == UPD_WR) ? upd_idx_q :
                    up_gnt            ? upd_idx_i : lookup_idx_i;
        mem_wdata = (state == INIT) ? CTR_INIT : bht_next_ctr(mem_rdata, upd_taken_q);
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state       <= INIT;
            init_idx    <= '0;
            starve      <= '0;
            pred_v_q    <= 1'b0;
            upd_idx_q   <= '0;
            upd_taken_q <= 1'b0;
        end else begin
            state       <= state_n;
            init_idx    <= (state == INIT && !flush_pend) ? init_idx + IDX_W'(1) : '0;
            starve      <= up_gnt ? '0 : (lk_gnt && upd_v_i) ? starve + SW'(1) : starve;
            pred_v_q    <= lk_gnt;
            if (up_gnt) begin
                upd_idx_q   <= upd_idx_i;
                upd_taken_q <= upd_taken_i;
            end
        end
    end

    bp_fe_bht_mem #(.IDX_W(IDX_W)) u_mem (
        .clk_i (clk_i),
        .en    (mem_en),
        .we    (mem_we),
        .addr  (mem_addr),
        .wdata (mem_wdata),
        .rdata (mem_rdata)
    );

    assign pred_v_o     = pred_v_q;
    assign pred_ctr_o   = pred_v_q ? mem_rdata : 2'b00;
    assign pred_taken_o = pred_ctr_o[1];
    assign init_done_o  = state != INIT;
endmodule
